hazard_stall_unit: RTL and testbench

// Pipeline control stage upstream of the forwarding unit: decides per cycle whether IF/ID and
// ID/EX advance, stall, bubble or flush. Detects load-use hazards that forwarding cannot cover,

---
 rtl/hazard_stall_unit_pkg.sv | 35 +++
 rtl/hazard_stall_unit_sat.sv | 35 +++
 rtl/hazard_stall_unit.sv | 111 +++++++++++
 tb/tb_hazard_stall_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: opcodes, hazard FSM encoding, NOP word.
// Imported by hazard_stall_unit and forward_unit.
package hazard_stall_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;
  localparam int REG_W   = 3;

  // Opcodes that matter to hazard and forwarding decisions
  localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b10001;
  localparam logic [OPC_W-1:0] OP_STU  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_LBI  = 5'b11000;
  localparam logic [OPC_W-1:0] OP_SLBI = 5'b10010;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_JALR = 5'b00111;

  // Word loaded into a pipeline register when it is bubbled or flushed
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'd0};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_HALT  = 2'd2
  } hsu_state_e;

  // True when a source operand is actually read and names the given register
  function automatic logic reg_match(input logic used,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at all-ones instead of wrapping
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Per-cycle pipeline control: load-use stall, branch flush, memory-busy freeze,
// sticky HALT, plus a saturating stall-cycle counter for performance debug.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LDUSE_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic [REG_W-1:0] dest_e,
  input  logic             dest_valid_e,
  input  logic             mem_read_ex,
  input  logic             br_taken_e,
  input  logic             halt_m,
  input  logic             mem_busy,
  output logic             stall_fd,
  output logic             bubble_de,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             freeze_all,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  // Extra bubbles still owed after the first one, loaded on hazard detection
  localparam logic [1:0] LDUSE_RELOAD = 2'(LDUSE_CYCLES - 1);

  hsu_state_e state_q, state_d;
  logic [1:0] ldcnt_q, ldcnt_d;
  logic       hazard;

  // Load in execute feeding a register that decode is about to read
  assign hazard = valid_d && mem_read_ex && dest_valid_e &&
                  (reg_match(use_rs_d, rs_d, dest_e) || reg_match(use_rt_d, rt_d, dest_e));

  // Next state and control outputs, in priority HALT > busy > branch > load-use > advance
  always_comb begin
    state_d    = state_q;
    ldcnt_d    = ldcnt_q;
    stall_fd   = 1'b0;
    bubble_de  = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    freeze_all = 1'b0;
    halted     = 1'b0;

    if (!rst) begin
      if (state_q == ST_HALT) begin
        halted     = 1'b1;
        freeze_all = 1'b1;
        stall_fd   = 1'b1;
      end else if (halt_m && !mem_busy) begin
        // HALT is retiring: fetch nothing more, let the back end drain it
        stall_fd = 1'b1;
        state_d  = ST_HALT;
        ldcnt_d  = 2'd0;
      end else if (mem_busy) begin
        // Whole pipe waits on data memory; pending load-use work is kept
        freeze_all = 1'b1;
        stall_fd   = 1'b1;
      end else if (br_taken_e) begin
        // Decode holds wrong-path work, so any pending load-use is moot
        flush_fd = 1'b1;
        flush_de = 1'b1;
        state_d  = ST_RUN;
        ldcnt_d  = 2'd0;
      end else if (state_q == ST_LDUSE) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
        ldcnt_d   = ldcnt_q - 2'd1;
        if (ldcnt_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end else if (hazard) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
        if (LDUSE_CYCLES > 1) begin
          state_d = ST_LDUSE;
          ldcnt_d = LDUSE_RELOAD;
        end
      end
    end
  end

  // FSM state and load-use countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ldcnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ldcnt_q <= ldcnt_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .en ((stall_fd || freeze_all) && !halted),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: two DUT configurations driven with shared stimulus and
// compared against a per-cycle behavioural model (remaining-bubble count + halt flag).
module tb_hazard_stall_unit;

  localparam int A_CNT_W = 16;
  localparam int B_CNT_W = 4;
  localparam int B_LDUSE = 3;

  logic       clk = 1'b0;
  logic       rst, valid_d, use_rs_d, use_rt_d, dest_valid_e;
  logic       mem_read_ex, br_taken_e, halt_m, mem_busy;
  logic [2:0] rs_d, rt_d, dest_e;

  logic a_stall_fd, a_bubble_de, a_flush_fd, a_flush_de, a_freeze_all, a_halted;
  logic b_stall_fd, b_bubble_de, b_flush_fd, b_flush_de, b_freeze_all, b_halted;
  logic [A_CNT_W-1:0] a_cnt;
  logic [B_CNT_W-1:0] b_cnt;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LDUSE_CYCLES(1), .CNT_W(A_CNT_W)) dut_a (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dest_e(dest_e),
    .dest_valid_e(dest_valid_e), .mem_read_ex(mem_read_ex),
    .br_taken_e(br_taken_e), .halt_m(halt_m), .mem_busy(mem_busy),
    .stall_fd(a_stall_fd), .bubble_de(a_bubble_de), .flush_fd(a_flush_fd),
    .flush_de(a_flush_de), .freeze_all(a_freeze_all), .halted(a_halted),
    .stall_cnt(a_cnt)
  );

  hazard_stall_unit #(.LDUSE_CYCLES(B_LDUSE), .CNT_W(B_CNT_W)) dut_b (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dest_e(dest_e),
    .dest_valid_e(dest_valid_e), .mem_read_ex(mem_read_ex),
    .br_taken_e(br_taken_e), .halt_m(halt_m), .mem_busy(mem_busy),
    .stall_fd(b_stall_fd), .bubble_de(b_bubble_de), .flush_fd(b_flush_fd),
    .flush_de(b_flush_de), .freeze_all(b_freeze_all), .halted(b_halted),
    .stall_cnt(b_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       valid_d;
    logic [2:0] rs_d;
    logic [2:0] rt_d;
    logic       use_rs_d;
    logic       use_rt_d;
    logic [2:0] dest_e;
    logic       dest_valid_e;
    logic       mem_read_ex;
    logic       br_taken_e;
    logic       halt_m;
    logic       mem_busy;
  } in_t;

  typedef struct packed {
    logic stall_fd;
    logic bubble_de;
    logic flush_fd;
    logic flush_de;
    logic freeze_all;
    logic halted;
  } out_t;

  // exp = {stall_fd, bubble_de, flush_fd, flush_de, freeze_all} for dut_a
  typedef struct {
    in_t        in;
    logic [4:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int rem_a, rem_b, cnt_a, cnt_b;
  bit hlt_a, hlt_b;
  bit cnt_known = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit v, bit [2:0] rs, bit [2:0] rt, bit urs, bit urt,
                             bit [2:0] de, bit dv, bit mr, bit br, bit busy);
    in_t x;
    x.rst = 1'b0;          x.valid_d = v;        x.rs_d = rs;
    x.rt_d = rt;           x.use_rs_d = urs;     x.use_rt_d = urt;
    x.dest_e = de;         x.dest_valid_e = dv;  x.mem_read_ex = mr;
    x.br_taken_e = br;     x.halt_m = 1'b0;      x.mem_busy = busy;
    return x;
  endfunction

  function automatic bit hazard_of(in_t v);
    return v.valid_d && v.mem_read_ex && v.dest_valid_e &&
           ((v.use_rs_d && v.rs_d == v.dest_e) || (v.use_rt_d && v.rt_d == v.dest_e));
  endfunction

  // Expected outputs this cycle given owed bubbles and halt flag
  function automatic out_t model_out(in_t v, int rem, bit hlt);
    out_t o = '0;
    if (!v.rst) begin
      if (hlt) begin
        o.halted = 1'b1; o.freeze_all = 1'b1; o.stall_fd = 1'b1;
      end else if (v.halt_m && !v.mem_busy) begin
        o.stall_fd = 1'b1;
      end else if (v.mem_busy) begin
        o.freeze_all = 1'b1; o.stall_fd = 1'b1;
      end else if (v.br_taken_e) begin
        o.flush_fd = 1'b1; o.flush_de = 1'b1;
      end else if (rem > 0 || hazard_of(v)) begin
        o.stall_fd = 1'b1; o.bubble_de = 1'b1;
      end
    end
    return o;
  endfunction

  // Model state across the clock edge
  task automatic model_adv(input in_t v, input out_t o, input int cycles, input int cmax,
                           inout int rem, inout bit hlt, inout int cnt);
    if (v.rst) begin
      rem = 0; hlt = 1'b0; cnt = 0;
    end else begin
      if ((o.stall_fd || o.freeze_all) && !o.halted && cnt < cmax) cnt++;
      if (!hlt) begin
        if (v.halt_m && !v.mem_busy) begin
          hlt = 1'b1; rem = 0;
        end else if (v.mem_busy) begin
          rem = rem;
        end else if (v.br_taken_e) begin
          rem = 0;
        end else if (rem > 0) begin
          rem--;
        end else if (hazard_of(v)) begin
          rem = cycles - 1;
        end
      end
    end
  endtask

  // One cycle: drive after the edge, check at the falling edge, advance the model
  task automatic step(input in_t v);
    out_t ea, eb, ga, gb;
    @(posedge clk);
    #1;
    {rst, valid_d, rs_d, rt_d, use_rs_d, use_rt_d, dest_e, dest_valid_e,
     mem_read_ex, br_taken_e, halt_m, mem_busy} = v;
    @(negedge clk);
    ea = model_out(v, rem_a, hlt_a);
    eb = model_out(v, rem_b, hlt_b);
    ga = {a_stall_fd, a_bubble_de, a_flush_fd, a_flush_de, a_freeze_all, a_halted};
    gb = {b_stall_fd, b_bubble_de, b_flush_fd, b_flush_de, b_freeze_all, b_halted};
    check("model_outs_a", 32'(ga), 32'(ea));
    check("model_outs_b", 32'(gb), 32'(eb));
    if (cnt_known) begin
      check("model_cnt_a", 32'(a_cnt), 32'(cnt_a));
      check("model_cnt_b", 32'(b_cnt), 32'(cnt_b));
    end
    model_adv(v, ea, 1, (1 << A_CNT_W) - 1, rem_a, hlt_a, cnt_a);
    model_adv(v, eb, B_LDUSE, (1 << B_CNT_W) - 1, rem_b, hlt_b, cnt_b);
    if (v.rst) cnt_known = 1'b1;
  endtask

  initial begin
    in_t  idle, rstv, hz, v;
    vec_t tbl[10];
    int   na, nb, nf;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstv = idle; rstv.rst = 1'b1;
    hz   = mk(1, 1, 3, 1, 0, 1, 1, 1, 0, 0);   // LD r1 in EX, ADD r2,r1,r3 in D
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0; hlt_a = 0; hlt_b = 0;

    {rst, valid_d, rs_d, rt_d, use_rs_d, use_rt_d, dest_e, dest_valid_e,
     mem_read_ex, br_taken_e, halt_m, mem_busy} = rstv;

    tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000};  // empty pipe
    tbl[1] = '{mk(1, 2, 0, 1, 0, 2, 1, 1, 0, 0), 5'b11000};  // rs hazard
    tbl[2] = '{mk(1, 0, 5, 0, 1, 5, 1, 1, 0, 0), 5'b11000};  // rt hazard
    tbl[3] = '{mk(1, 0, 5, 0, 0, 5, 1, 1, 0, 0), 5'b00000};  // rt matches but unused
    tbl[4] = '{mk(0, 2, 2, 1, 1, 2, 1, 1, 0, 0), 5'b00000};  // decode is a bubble
    tbl[5] = '{mk(1, 2, 2, 1, 1, 2, 1, 0, 0, 0), 5'b00000};  // not a load
    tbl[6] = '{mk(1, 2, 0, 1, 0, 2, 1, 1, 0, 1), 5'b10001};  // busy beats hazard
    tbl[7] = '{mk(1, 2, 0, 1, 0, 2, 1, 1, 1, 0), 5'b00110};  // branch beats hazard
    tbl[8] = '{mk(1, 2, 0, 1, 0, 2, 1, 1, 1, 1), 5'b10001};  // busy beats branch
    tbl[9] = '{mk(1, 6, 7, 1, 1, 4, 1, 1, 0, 0), 5'b00000};  // no register match

    // Reset state
    step(rstv);
    step(rstv);
    check("rst_outs_a", 32'({a_stall_fd, a_bubble_de, a_flush_fd, a_flush_de, a_freeze_all, a_halted}), 32'd0);
    step(idle);
    check("rst_cnt_a", 32'(a_cnt), 32'd0);

    // Single-cycle decisions from RUN
    foreach (tbl[i]) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i),
            32'({a_stall_fd, a_bubble_de, a_flush_fd, a_flush_de, a_freeze_all}),
            32'(tbl[i].exp));
    end

    // Load-use: one bubble on dut_a, three on dut_b
    step(rstv);
    step(idle);
    na = 0; nb = 0;
    step(hz);
    check("lduse_first", 32'({a_stall_fd, a_bubble_de}), 32'b11);
    na += int'(a_stall_fd); nb += int'(b_stall_fd);
    for (int i = 0; i < 4; i++) begin
      step(idle);
      na += int'(a_stall_fd && a_bubble_de); nb += int'(b_stall_fd && b_bubble_de);
    end
    check("lduse_cycles_a", 32'(na), 32'd1);
    check("lduse_cycles_b", 32'(nb), 32'd3);
    check("lduse_cnt_a", 32'(a_cnt), 32'd1);
    check("lduse_cnt_b", 32'(b_cnt), 32'd3);

    // Load with no consumer, and non-writing execute instruction
    step(mk(1, 4, 5, 1, 1, 1, 1, 1, 0, 0));
    check("nocons_a", 32'({a_stall_fd, a_bubble_de, a_flush_fd, a_flush_de, a_freeze_all}), 32'd0);
    check("nocons_b", 32'({b_stall_fd, b_bubble_de, b_flush_fd, b_flush_de, b_freeze_all}), 32'd0);
    step(mk(1, 1, 1, 1, 1, 1, 0, 1, 0, 0));
    check("nodest_b", 32'({b_stall_fd, b_bubble_de}), 32'd0);

    // Hazard and taken branch together: flush wins, nothing owed afterwards
    v = hz; v.br_taken_e = 1'b1;
    step(v);
    check("br_hz_b", 32'({b_flush_fd, b_flush_de, b_bubble_de, b_stall_fd}), 32'b1100);
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      step(idle);
      nb += int'(b_stall_fd);
    end
    check("br_hz_after_b", 32'(nb), 32'd0);

    // Memory busy for 4 cycles inside LDUSE
    step(hz);
    v = hz; v.mem_busy = 1'b1;
    nf = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      step(v);
      nf += int'(b_freeze_all); nb += int'(b_bubble_de);
    end
    check("busy_freeze_b", 32'(nf), 32'd4);
    check("busy_bubble_b", 32'(nb), 32'd0);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      step(idle);
      nb += int'(b_stall_fd && b_bubble_de);
    end
    check("busy_resume_b", 32'(nb), 32'd2);

    // HALT held off by busy, then sticky until reset
    step(rstv);
    v = idle; v.halt_m = 1'b1; v.mem_busy = 1'b1;
    step(v);
    step(v);
    check("halt_busy_a", 32'(a_halted), 32'd0);
    v.mem_busy = 1'b0;
    step(v);
    check("halt_entry_a", 32'({a_halted, a_stall_fd}), 32'b01);
    na = 0;
    for (int i = 0; i < 100; i++) begin
      step(hz);
      na += int'(a_halted && b_halted && a_freeze_all);
    end
    check("halt_sticky", 32'(na), 32'd100);
    check("halt_cnt_a", 32'(a_cnt), 32'd3);
    step(rstv);
    check("halt_rst_a", 32'({a_stall_fd, a_freeze_all, a_halted}), 32'd0);
    step(hz);
    check("halt_run_a", 32'({a_stall_fd, a_bubble_de, a_halted}), 32'b110);

    // Counter saturation on the 4-bit instance
    step(rstv);
    v = idle; v.mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) step(v);
    step(idle);
    check("sat_cnt_b", 32'(b_cnt), 32'd15);
    check("sat_cnt_a", 32'(a_cnt), 32'd20);

    // Reset mid-LDUSE leaves no residual bubble
    step(hz);
    step(rstv);
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      step(idle);
      nb += int'(b_stall_fd);
    end
    check("rst_mid_lduse_b", 32'(nb), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v.rst          = ($urandom_range(0, 39) == 0);
      v.valid_d      = ($urandom_range(0, 3) != 0);
      v.rs_d         = 3'($urandom_range(0, 3));
      v.rt_d         = 3'($urandom_range(0, 3));
      v.use_rs_d     = $urandom_range(0, 1) != 0;
      v.use_rt_d     = $urandom_range(0, 1) != 0;
      v.dest_e       = 3'($urandom_range(0, 3));
      v.dest_valid_e = ($urandom_range(0, 3) != 0);
      v.mem_read_ex  = $urandom_range(0, 1) != 0;
      v.br_taken_e   = ($urandom_range(0, 5) == 0);
      v.halt_m       = ($urandom_range(0, 59) == 0);
      v.mem_busy     = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
